seven_segment_scanner: RTL
==========================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have parameter DIV, default 100000: clock cycles per digit slot, legal range >= 2.
REQ-002 The block SHALL have parameter BLANK_CYC, default 16: blanking cycles at the end of each slot, legal range 1..DIV-1.
REQ-003 The block SHALL have port clk  in  1  the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port digit  in  32  eight 4-bit hex codes; digit[4i+3:4i] is display position i.
REQ-006 The block SHALL have port en_dot  in  8  decimal-point enable, bit i for position i.
REQ-007 The block SHALL have port en_digit  in  8  digit enable, bit i for position i; 0 blanks the position.
REQ-008 The block SHALL have port an  out  8  active-low anode select, one-hot-low or all ones.
REQ-009 The block SHALL have port seg  out  7  active-low cathodes, {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp  out  1  active-low decimal point.
REQ-011 The block SHALL have port frame_start  out  1  one-cycle pulse on every snapshot load.

Function
REQ-012 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; its width SHALL be $clog2(DIV).
REQ-013 The slot-end condition is cnt==DIV-1; on slot end, idx SHALL advance by one; from idx 7 it SHALL wrap to 0.
REQ-014 A snapshot of digit, en_dot and en_digit SHALL load when (slot end and idx==7), or on the first cycle after reset release (load_pending flag); the inputs are not sampled at any other time.
REQ-015 frame_start SHALL be asserted in the cycle after each snapshot load.
REQ-016 Input changes between loads SHALL NOT affect the outputs, so no frame ever tears.
REQ-017 Outputs SHALL be registered, with one cycle of latency from idx/cnt to an, seg and dp.
REQ-018 When snap_en_digit[idx]=1: an SHALL have only bit idx low; seg SHALL be the decode of snap_digit[idx]; dp SHALL be ~snap_en_dot[idx].
REQ-019 When snap_en_digit[idx]=0: an SHALL be 8'hFF, seg SHALL be 7'h7F and dp SHALL be 1.
REQ-020 The decode SHALL use seg = {g..a} active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-021 Only one anode SHALL ever be low in any cycle.
REQ-022 During a blanking window, an SHALL be 8'hFF.
REQ-023 When the snapshot load and the slot wrap coincide, the new snapshot SHALL apply to idx 0.

Reset
REQ-024 While rst=0 at a clock edge, the block SHALL set: cnt=0, idx=0, an=FF, seg=7F, dp=1, frame_start=0, snapshot digit=FFFFFFFF, snapshot en_dot=00, snapshot en_digit=00, load_pending=1.
REQ-025 Reset asserted mid-slot or mid-frame SHALL abort the scan immediately; after release, scanning SHALL restart at idx 0 with a fresh snapshot.

Configuration
REQ-026 The feature is controlled by macro SEVEN_SEGMENT_BLANK_GAP_EN.
REQ-027 When SEVEN_SEGMENT_BLANK_GAP_EN is defined, an SHALL be forced to FF while cnt >= DIV-BLANK_CYC (anti-ghosting); seg and dp SHALL still follow REQ-018.
REQ-028 When SEVEN_SEGMENT_BLANK_GAP_EN is undefined, the anode SHALL stay active for the full slot and BLANK_CYC is ignored.

Structure
REQ-029 Package seven_segment_pkg SHALL hold the 16-entry segment decode constant table, the blank constants (AN_OFF=FF, SEG_OFF=7F) and the digit-index typedef (3 bits).
REQ-030 The decode SHALL be a combinational sub-module seven_segment_decoder (4-bit code in, 7-bit seg out), instantiated once.

Verification (DIV=4, BLANK_CYC=1)
REQ-031 Bench SHALL check: rst=0 for 3 cycles -> an=FF, seg=7F, dp=1, frame_start=0; after release, frame_start pulses once at cycle 1.
REQ-032 Bench SHALL check: digit=76543210, en_digit=FF, en_dot=00 -> an steps FE,FD,...,7F, each held 4 cycles (3 with gap), with seg 40,79,24,30,19,12,02,78; dp=1.
REQ-033 Bench SHALL check: digit is changed to FFFFFFFF while idx=3 -> positions 3..7 still show the old values; the new value appears from idx 0 after the next frame_start.
REQ-034 Bench SHALL check: en_digit=0x05, en_dot=0x04 -> only positions 0 and 2 light, dp=0 only at position 2; all other slots show an=FF, seg=7F.
REQ-035 Bench SHALL check: with the macro defined, an=FF on cnt=3 of every slot; with the macro undefined, an is never FF during slots of enabled digits.
REQ-036 Bench SHALL check: rst=0 applied at idx=5, cnt=2 -> outputs blank next cycle; after release, scanning resumes at an=FE with a fresh snapshot.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared segment decode table, blank constants and digit-index type
package seven_segment_pkg;
   typedef logic [2:0] digit_idx_t;
   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   // active-low {g,f,e,d,c,b,a} patterns for hex codes 0..F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
endpackage

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: combinational hex code to active-low segment pattern
module seven_segment_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);
   // table lookup of the cathode pattern
   always_comb seg = SEG_TABLE[code];
endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: 8-digit multiplexed display scanner with tear-free frame snapshots; SEVEN_SEGMENT_BLANK_GAP_EN adds an anode-off gap at each slot end
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digit,
   input  logic [7:0]  en_dot,
   input  logic [7:0]  en_digit,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);
   localparam int CW = $clog2(DIV);
`ifdef SEVEN_SEGMENT_BLANK_GAP_EN
   localparam int GAP_AT = DIV - BLANK_CYC;
`else
   // threshold past the last count value, so the gap never opens
   localparam int GAP_AT = DIV + 0 * BLANK_CYC;
`endif
   logic [CW-1:0] cnt;
   digit_idx_t    idx;
   logic [31:0]   snap_digit;
   logic [7:0]    snap_en_dot;
   logic [7:0]    snap_en_digit;
   logic          load_pending;
   logic          slot_end;
   logic          load;
   logic          lit;
   logic          gap;
   logic [6:0]    dec_seg;

   // slot timing, snapshot trigger and current-position qualifiers
   always_comb begin
      slot_end = cnt == CW'(DIV - 1);
      load     = load_pending | (slot_end & (idx == 3'd7));
      lit      = snap_en_digit[idx];
      gap      = int'(cnt) >= GAP_AT;
   end

   seven_segment_decoder u_dec (
      .code (snap_digit[{idx, 2'b00} +: 4]),
      .seg  (dec_seg)
   );

   // prescaler, digit index, frame snapshot and registered display outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt           <= '0;
         idx           <= '0;
         snap_digit    <= 32'hFFFF_FFFF;
         snap_en_dot   <= 8'h00;
         snap_en_digit <= 8'h00;
         load_pending  <= 1'b1;
         frame_start   <= 1'b0;
         an            <= AN_OFF;
         seg           <= SEG_OFF;
         dp            <= 1'b1;
      end else begin
         cnt          <= slot_end ? '0 : cnt + CW'(1);
         idx          <= slot_end ? idx + 3'd1 : idx;
         load_pending <= 1'b0;
         frame_start  <= load;
         if (load) begin
            snap_digit    <= digit;
            snap_en_dot   <= en_dot;
            snap_en_digit <= en_digit;
         end
         an  <= (lit && !gap) ? ~(8'h01 << idx) : AN_OFF;
         seg <= lit ? dec_seg : SEG_OFF;
         dp  <= lit ? ~snap_en_dot[idx] : 1'b1;
      end
   end
endmodule
